// File: rtl/scan_ctrl_8_pkg.sv
// rtl/scan_ctrl_8_pkg.sv - shared display scan types and constants
package scan_ctrl_8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_DEAD
    } scan_state_e;

    localparam logic [7:0] DIG_OFF    = 8'hFF;
    localparam int         MAX_DIGITS = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/scan_ctrl_8_prescaler.sv
// rtl/scan_ctrl_8_prescaler.sv - interval counter with terminal-count pulse
module scan_prescaler #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] last,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    assign tc = (count == last);

    // Wraps on its own at terminal count, so back-to-back intervals need no clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || tc) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/scan_ctrl_8.sv
// rtl/scan_ctrl_8.sv - 8-digit seven-segment scan controller with dead-time blanking
module scan_ctrl_8
    import scan_ctrl_8_pkg::*;
#(
    parameter int DIV_CNT  = 50000,
    parameter int DEAD_CNT = 500,
    parameter int DIGITS   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] digit_mask,
    output logic [2:0] SEL,
    output logic [7:0] DIG,
    output logic       blank,
    output logic       frame_done
);

    localparam int              CNT_W     = $clog2(max3(DIV_CNT, DEAD_CNT, 2));
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(DIV_CNT - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CNT > 0) ? DEAD_CNT - 1 : 0);
    localparam logic [2:0]       LAST_SEL  = 3'(DIGITS - 1);
    localparam bit               HAS_DEAD  = (DEAD_CNT > 0);

    generate
        if (DIV_CNT < 1 || DEAD_CNT < 0 || DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_params
            $error("scan_ctrl_8: illegal DIV_CNT/DEAD_CNT/DIGITS");
        end
    endgenerate

    scan_state_e      state_q, state_d;
    logic [2:0]       sel_d;
    logic [7:0]       dig_d;
    logic             blank_d, frame_d, advance, lit, clr, tc;
    logic [CNT_W-1:0] last;

    assign clr  = (state_q == ST_IDLE) || (state_d == ST_IDLE);
    assign last = (state_q == ST_DEAD) ? DEAD_LAST : SHOW_LAST;

    scan_prescaler #(.WIDTH(CNT_W)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .last  (last),
        .tc    (tc)
    );

    // Outputs are decoded from the next state so they land in registers together with it.
    always_comb begin
        state_d = state_q;
        sel_d   = SEL;
        advance = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            sel_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SHOW;
                    sel_d   = '0;
                end
                ST_SHOW: begin
                    if (tc) begin
                        if (HAS_DEAD) begin
                            state_d = ST_DEAD;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
                ST_DEAD: begin
                    if (tc) begin
                        state_d = ST_SHOW;
                        advance = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                end
            endcase
        end
        if (advance) begin
            sel_d = (SEL == LAST_SEL) ? 3'd0 : SEL + 3'd1;
        end
        lit   = (state_d == ST_SHOW) && digit_mask[sel_d];
        dig_d = DIG_OFF;
        if (lit) begin
            dig_d[sel_d] = 1'b0;
        end
        blank_d = !lit;
        frame_d = advance && (sel_d == 3'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            SEL        <= '0;
            DIG        <= DIG_OFF;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            SEL        <= sel_d;
            DIG        <= dig_d;
            blank      <= blank_d;
            frame_done <= frame_d;
        end
    end

endmodule
